// File: rtl/xsimbus_rr_if.sv
// Bus bundle for xsimbus_rr: master request side plus device side.
// "master" is the interconnect's view (drives grants/strobes); "slave" is the attached environment's view.
interface xsimbus_rr_if #(
   parameter int N_MASTERS = 4,
   parameter int N_DEVICES = 32,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int ID_W      = 5
);
   logic [N_MASTERS-1:0]        req_in;
   logic [N_MASTERS-1:0]        rw_in;
   logic [N_MASTERS*ADDR_W-1:0] addr_in;
   logic [N_MASTERS*DATA_W-1:0] wdata_in;
   logic [N_DEVICES*DATA_W-1:0] dev_rdata_in;
   logic [N_DEVICES-1:0]        dev_ready_in;
   logic [N_MASTERS-1:0]        grant_out;
   logic [N_DEVICES-1:0]        dev_sel_out;
   logic [ID_W-1:0]             master_id_out;
   logic [ID_W-1:0]             device_id_out;
   logic [ADDR_W-1:0]           addr_out;
   logic [DATA_W-1:0]           wdata_out;
   logic                        rw_out;
   logic [DATA_W-1:0]           rdata_out;
   logic [N_MASTERS-1:0]        ack_out;
   logic                        err_out;
   logic                        hold_flag_out;

   modport master (
      input  req_in, rw_in, addr_in, wdata_in, dev_rdata_in, dev_ready_in,
      output grant_out, dev_sel_out, master_id_out, device_id_out, addr_out,
             wdata_out, rw_out, rdata_out, ack_out, err_out, hold_flag_out
   );

   modport slave (
      output req_in, rw_in, addr_in, wdata_in, dev_rdata_in, dev_ready_in,
      input  grant_out, dev_sel_out, master_id_out, device_id_out, addr_out,
             wdata_out, rw_out, rdata_out, ack_out, err_out, hold_flag_out
   );
endinterface

// File: rtl/xsimbus_rr.sv
// Round-robin single-transaction shared bus: arbitrate in IDLE, hold one slave in ACCESS
// until ready or timeout, then pulse ack to the owner for one cycle.
module xsimbus_rr #(
   parameter int N_MASTERS   = 4,
   parameter int N_DEVICES   = 32,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int SEL_W       = 5,
   parameter int ID_W        = 5,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic          clk,
   input  logic          rst,
   xsimbus_rr_if.master  bus
);
   localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYC) + 1;

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t              state_q, state_d;
   logic [MW-1:0]       last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [N_MASTERS-1:0] grant_q, grant_d;
   logic [ID_W-1:0]     mid_q, mid_d;
   logic [SEL_W-1:0]    dev_q, dev_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                rw_q, rw_d;
   logic                err_q, err_d;

   logic [ADDR_W-1:0]   m_addr  [N_MASTERS];
   logic [DATA_W-1:0]   m_wdata [N_MASTERS];
   logic [DATA_W-1:0]   d_rdata [N_DEVICES];
   logic [N_DEVICES-1:0] dev_sel;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;
   logic [MW-1:0]       win;
   logic                found;
   logic [SEL_W-1:0]    win_dev;

   genvar gi;
   generate
      for (gi = 0; gi < N_MASTERS; gi++) begin : g_master
         assign m_addr[gi]  = bus.addr_in[gi*ADDR_W +: ADDR_W];
         assign m_wdata[gi] = bus.wdata_in[gi*DATA_W +: DATA_W];
      end
      for (gi = 0; gi < N_DEVICES; gi++) begin : g_device
         assign d_rdata[gi] = bus.dev_rdata_in[gi*DATA_W +: DATA_W];
         assign dev_sel[gi] = (state_q == ACCESS) && (32'(dev_q) == gi);
      end
   endgenerate

   // Only the selected slave's ready/data can reach the FSM.
   always_comb begin
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int d = 0; d < N_DEVICES; d++) begin
         if (dev_sel[d]) begin
            sel_ready = bus.dev_ready_in[d];
            sel_rdata = d_rdata[d];
         end
      end
   end

   // Scan last+1, last+2, ... so the previous owner is considered last.
   always_comb begin
      win   = last_q;
      found = 1'b0;
      for (int k = 1; k <= N_MASTERS; k++) begin
         int            c;
         logic [MW-1:0] cand;
         c = int'(last_q) + k;
         if (c >= N_MASTERS) c = c - N_MASTERS;
         cand = MW'(c);
         if (!found && bus.req_in[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
      win_dev = m_addr[win][ADDR_W-1 -: SEL_W];
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      mid_d   = mid_q;
      dev_d   = dev_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      rw_d    = rw_q;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d      = '0;
               grant_d[win] = 1'b1;
               mid_d        = ID_W'(win);
               last_d       = win;
               addr_d       = m_addr[win];
               wdata_d      = m_wdata[win];
               rw_d         = bus.rw_in[win];
               dev_d        = win_dev;
               cnt_d        = '0;
               if (32'(win_dev) >= N_DEVICES) begin
                  state_d = ACK;
                  err_d   = 1'b1;
                  rdata_d = '1;
               end else begin
                  state_d = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (sel_ready) begin
               state_d = ACK;
               err_d   = 1'b0;
               rdata_d = rw_q ? '0 : sel_rdata;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d = ACK;
               err_d   = 1'b1;
               rdata_d = '1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ACK: begin
            state_d = IDLE;
            grant_d = '0;
            mid_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= MW'(N_MASTERS - 1);
         cnt_q   <= '0;
         grant_q <= '0;
         mid_q   <= '0;
         dev_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
         mid_q   <= mid_d;
         dev_q   <= dev_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         rw_q    <= rw_d;
         err_q   <= err_d;
      end
   end

   assign bus.grant_out     = grant_q;
   assign bus.dev_sel_out   = dev_sel;
   assign bus.master_id_out = mid_q;
   assign bus.device_id_out = ID_W'(dev_q);
   assign bus.addr_out      = addr_q;
   assign bus.wdata_out     = wdata_q;
   assign bus.rw_out        = rw_q;
   assign bus.rdata_out     = rdata_q;
   assign bus.ack_out       = (state_q == ACK) ? grant_q : '0;
   assign bus.err_out       = err_q;
   assign bus.hold_flag_out = (state_q != IDLE);
endmodule

// File: tb/tb_xsimbus_rr.sv
// Directed bench for xsimbus_rr: a 32-device instance for most scenarios and an
// 8-device instance for unmapped-address decoding. Inputs change and outputs are sampled on negedge.
module tb_xsimbus_rr;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   xsimbus_rr_if #(.N_MASTERS(4), .N_DEVICES(32), .ADDR_W(32), .DATA_W(32), .ID_W(5)) bus ();
   xsimbus_rr_if #(.N_MASTERS(4), .N_DEVICES(8),  .ADDR_W(32), .DATA_W(32), .ID_W(5)) bus8 ();

   xsimbus_rr #(.N_MASTERS(4), .N_DEVICES(32), .ADDR_W(32), .DATA_W(32), .SEL_W(5),
                .ID_W(5), .TIMEOUT_CYC(16)) u_dut (.clk(clk), .rst(rst), .bus(bus));
   xsimbus_rr #(.N_MASTERS(4), .N_DEVICES(8), .ADDR_W(32), .DATA_W(32), .SEL_W(5),
                .ID_W(5), .TIMEOUT_CYC(16)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      bus.req_in = '0;  bus.rw_in = '0;  bus.addr_in = '0;  bus.wdata_in = '0;
      bus.dev_rdata_in = '0;  bus.dev_ready_in = '0;
      bus8.req_in = '0; bus8.rw_in = '0; bus8.addr_in = '0; bus8.wdata_in = '0;
      bus8.dev_rdata_in = '0; bus8.dev_ready_in = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_master(input int m, input logic rw, input logic [31:0] a, input logic [31:0] wd);
      bus.req_in[m] = 1'b1;
      bus.rw_in[m]  = rw;
      bus.addr_in[m*32 +: 32]  = a;
      bus.wdata_in[m*32 +: 32] = wd;
   endtask

   task automatic set_dev(input int d, input logic rdy, input logic [31:0] data);
      bus.dev_ready_in[d] = rdy;
      bus.dev_rdata_in[d*32 +: 32] = data;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (bus.grant_out !== 4'b0000) begin bad++; $display("FAIL reset_grant: got %b want 0000", bus.grant_out); end
      total++; if (bus.ack_out !== 4'b0000) begin bad++; $display("FAIL reset_ack: got %b want 0000", bus.ack_out); end
      total++; if (bus.dev_sel_out !== 32'h0) begin bad++; $display("FAIL reset_sel: got %h want 0", bus.dev_sel_out); end
      total++; if (bus.hold_flag_out !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", bus.hold_flag_out); end
      total++; if (bus.addr_out !== 32'h0) begin bad++; $display("FAIL reset_addr: got %h want 0", bus.addr_out); end
      total++; if (bus.rdata_out !== 32'h0 || bus.err_out !== 1'b0) begin bad++; $display("FAIL reset_rdata_err: got %h/%b want 0/0", bus.rdata_out, bus.err_out); end
      total++; if (bus.master_id_out !== 5'd0 || bus.device_id_out !== 5'd0) begin bad++; $display("FAIL reset_ids: got %0d/%0d want 0/0", bus.master_id_out, bus.device_id_out); end
      total++; if (bus8.hold_flag_out !== 1'b0) begin bad++; $display("FAIL reset_hold8: got %b want 0", bus8.hold_flag_out); end
      $display("reset: outputs checked");
   endtask

   task automatic test_single_read();
      do_reset();
      set_dev(0, 1'b0, 32'h12345678);
      set_master(0, 1'b0, 32'h00000010, 32'h0);
      tick(); // cycle 1
      total++; if (bus.grant_out !== 4'b0001) begin bad++; $display("FAIL rd_grant: got %b want 0001", bus.grant_out); end
      total++; if (bus.dev_sel_out !== 32'h1 || bus.hold_flag_out !== 1'b1) begin bad++; $display("FAIL rd_sel: got %h/%b want 1/1", bus.dev_sel_out, bus.hold_flag_out); end
      total++; if (bus.addr_out !== 32'h10 || bus.rw_out !== 1'b0) begin bad++; $display("FAIL rd_addr: got %h/%b want 10/0", bus.addr_out, bus.rw_out); end
      tick(); // cycle 2
      total++; if (bus.ack_out !== 4'b0000) begin bad++; $display("FAIL rd_noack2: got %b want 0000", bus.ack_out); end
      tick(); // cycle 3
      total++; if (bus.ack_out !== 4'b0000) begin bad++; $display("FAIL rd_noack3: got %b want 0000", bus.ack_out); end
      set_dev(0, 1'b1, 32'h12345678);
      tick(); // cycle 4
      total++; if (bus.ack_out !== 4'b0001) begin bad++; $display("FAIL rd_ack: got %b want 0001", bus.ack_out); end
      total++; if (bus.rdata_out !== 32'h12345678 || bus.err_out !== 1'b0) begin bad++; $display("FAIL rd_data: got %h/%b want 12345678/0", bus.rdata_out, bus.err_out); end
      total++; if (bus.dev_sel_out !== 32'h0 || bus.grant_out !== 4'b0001) begin bad++; $display("FAIL rd_ackstate: got sel %h grant %b want 0/0001", bus.dev_sel_out, bus.grant_out); end
      bus.req_in[0] = 1'b0;
      set_dev(0, 1'b0, 32'h0);
      tick(); // cycle 5
      total++; if (bus.hold_flag_out !== 1'b0 || bus.grant_out !== 4'b0000 || bus.ack_out !== 4'b0000) begin bad++; $display("FAIL rd_idle: got hold %b grant %b ack %b want 0/0000/0000", bus.hold_flag_out, bus.grant_out, bus.ack_out); end
      total++; if (bus.rdata_out !== 32'h12345678) begin bad++; $display("FAIL rd_hold_rdata: got %h want 12345678", bus.rdata_out); end
      $display("single read: done");
   endtask

   task automatic test_round_robin();
      logic [3:0]  exp_g;
      logic [31:0] exp_d;
      do_reset();
      for (int d = 0; d < 32; d++) set_dev(d, 1'b1, 32'h1000 + d);
      for (int m = 0; m < 3; m++) set_master(m, 1'b0, m << 27, 32'h0);
      for (int k = 0; k < 6; k++) begin
         exp_g = 4'b0001 << (k % 3);
         exp_d = 32'h1000 + (k % 3);
         tick();
         total++; if (bus.grant_out !== exp_g || bus.hold_flag_out !== 1'b1) begin bad++; $display("FAIL rr_grant[%0d]: got %b/%b want %b/1", k, bus.grant_out, bus.hold_flag_out, exp_g); end
         tick();
         total++; if (bus.ack_out !== exp_g || bus.rdata_out !== exp_d) begin bad++; $display("FAIL rr_ack[%0d]: got %b/%h want %b/%h", k, bus.ack_out, bus.rdata_out, exp_g, exp_d); end
         tick();
         total++; if (bus.hold_flag_out !== 1'b0) begin bad++; $display("FAIL rr_gap[%0d]: got hold %b want 0", k, bus.hold_flag_out); end
         if (k == 5) bus.req_in = '0;
         $display("rr txn %0d: grant=%b", k, bus.grant_out);
      end
      tick();
   endtask

   task automatic test_write();
      do_reset();
      set_dev(29, 1'b0, 32'hDEADBEEF);
      set_master(3, 1'b1, 32'hE8000004, 32'hA5A5A5A5);
      tick(); // cycle 1
      total++; if (bus.dev_sel_out !== 32'h20000000 || bus.device_id_out !== 5'd29) begin bad++; $display("FAIL wr_sel: got %h/%0d want 20000000/29", bus.dev_sel_out, bus.device_id_out); end
      total++; if (bus.wdata_out !== 32'hA5A5A5A5 || bus.rw_out !== 1'b1) begin bad++; $display("FAIL wr_data: got %h/%b want a5a5a5a5/1", bus.wdata_out, bus.rw_out); end
      total++; if (bus.grant_out !== 4'b1000 || bus.master_id_out !== 5'd3) begin bad++; $display("FAIL wr_grant: got %b/%0d want 1000/3", bus.grant_out, bus.master_id_out); end
      set_master(3, 1'b0, 32'h00000000, 32'h0);
      bus.req_in[3] = 1'b0;
      set_dev(5, 1'b1, 32'h5555);
      tick(); // cycle 2
      total++; if (bus.addr_out !== 32'hE8000004 || bus.wdata_out !== 32'hA5A5A5A5 || bus.rw_out !== 1'b1) begin bad++; $display("FAIL wr_latched: got %h/%h/%b want e8000004/a5a5a5a5/1", bus.addr_out, bus.wdata_out, bus.rw_out); end
      tick(); // cycle 3
      total++; if (bus.ack_out !== 4'b0000 || bus.dev_sel_out !== 32'h20000000) begin bad++; $display("FAIL wr_ignore_other: got ack %b sel %h want 0000/20000000", bus.ack_out, bus.dev_sel_out); end
      set_dev(29, 1'b1, 32'hDEADBEEF);
      tick(); // cycle 4
      total++; if (bus.ack_out !== 4'b1000 || bus.err_out !== 1'b0) begin bad++; $display("FAIL wr_ack: got %b/%b want 1000/0", bus.ack_out, bus.err_out); end
      total++; if (bus.rdata_out !== 32'h0) begin bad++; $display("FAIL wr_rdata: got %h want 0", bus.rdata_out); end
      $display("write: done");
   endtask

   task automatic test_timeout();
      do_reset();
      set_master(2, 1'b0, 32'h08000000, 32'h0);
      tick(); // cycle 1: ACCESS entry
      total++; if (bus.grant_out !== 4'b0100 || bus.device_id_out !== 5'd1) begin bad++; $display("FAIL to_grant: got %b/%0d want 0100/1", bus.grant_out, bus.device_id_out); end
      set_master(1, 1'b0, 32'h00000000, 32'h0);
      for (int c = 2; c <= 16; c++) begin
         tick();
         total++; if (bus.ack_out !== 4'b0000) begin bad++; $display("FAIL to_early_ack[c%0d]: got %b want 0000", c, bus.ack_out); end
      end
      tick(); // cycle 17
      total++; if (bus.ack_out !== 4'b0100 || bus.err_out !== 1'b1) begin bad++; $display("FAIL to_ack: got %b/%b want 0100/1", bus.ack_out, bus.err_out); end
      total++; if (bus.rdata_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL to_rdata: got %h want ffffffff", bus.rdata_out); end
      bus.req_in[2] = 1'b0;
      tick(); // cycle 18
      total++; if (bus.hold_flag_out !== 1'b0) begin bad++; $display("FAIL to_idle: got hold %b want 0", bus.hold_flag_out); end
      tick(); // cycle 19
      total++; if (bus.grant_out !== 4'b0010) begin bad++; $display("FAIL to_next: got %b want 0010", bus.grant_out); end
      $display("timeout: done");
   endtask

   task automatic test_unmapped();
      do_reset();
      bus8.req_in[1] = 1'b1;
      bus8.addr_in[32 +: 32] = 32'hF8000000;
      tick(); // cycle 1
      total++; if (bus8.ack_out !== 4'b0010 || bus8.err_out !== 1'b1) begin bad++; $display("FAIL um_ack: got %b/%b want 0010/1", bus8.ack_out, bus8.err_out); end
      total++; if (bus8.rdata_out !== 32'hFFFFFFFF) begin bad++; $display("FAIL um_rdata: got %h want ffffffff", bus8.rdata_out); end
      total++; if (bus8.dev_sel_out !== 8'h00 || bus8.device_id_out !== 5'd31) begin bad++; $display("FAIL um_sel: got %h/%0d want 00/31", bus8.dev_sel_out, bus8.device_id_out); end
      total++; if (bus8.grant_out !== 4'b0010 || bus8.hold_flag_out !== 1'b1) begin bad++; $display("FAIL um_grant: got %b/%b want 0010/1", bus8.grant_out, bus8.hold_flag_out); end
      bus8.req_in = '0;
      tick(); // cycle 2
      total++; if (bus8.hold_flag_out !== 1'b0 || bus8.ack_out !== 4'b0000) begin bad++; $display("FAIL um_idle: got %b/%b want 0/0000", bus8.hold_flag_out, bus8.ack_out); end
      $display("unmapped: done");
   endtask

   task automatic test_reset_midop();
      do_reset();
      set_master(0, 1'b0, 32'h10000000, 32'h0);
      tick(); // cycle 1
      total++; if (bus.hold_flag_out !== 1'b1 || bus.dev_sel_out !== 32'h4) begin bad++; $display("FAIL mr_access: got %b/%h want 1/4", bus.hold_flag_out, bus.dev_sel_out); end
      tick(); // cycle 2
      rst = 1'b1;
      tick(); // cycle 3
      total++; if (bus.grant_out !== 4'b0000 || bus.ack_out !== 4'b0000 || bus.hold_flag_out !== 1'b0) begin bad++; $display("FAIL mr_cleared: got %b/%b/%b want 0000/0000/0", bus.grant_out, bus.ack_out, bus.hold_flag_out); end
      total++; if (bus.dev_sel_out !== 32'h0 || bus.addr_out !== 32'h0 || bus.device_id_out !== 5'd0) begin bad++; $display("FAIL mr_outs: got %h/%h/%0d want 0/0/0", bus.dev_sel_out, bus.addr_out, bus.device_id_out); end
      rst = 1'b0;
      set_master(1, 1'b0, 32'h0, 32'h0);
      tick(); // cycle 4
      total++; if (bus.grant_out !== 4'b0001 || bus.master_id_out !== 5'd0) begin bad++; $display("FAIL mr_first: got %b/%0d want 0001/0", bus.grant_out, bus.master_id_out); end
      $display("reset mid-op: done");
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_timeout();
      test_unmapped();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end
endmodule
